// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings for the fetch/data memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [3:0] STREAK_MAX = 4'd15;

  // Size code 2'b11 is folded into the word case.
  function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b1111;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr_lo;
      SZ_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_strb_gen.sv
// ============================================================================
// Module   : mem_strb_gen
// Brief    : Byte-enable generator from access size and low address bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_strb_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = size_to_strb(size, addr_lo);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one req/addr_ok/data_ok memory port between fetch and
//            data requesters; data has priority, fetch has a starvation cap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] C_LIMIT = 4'((STARVE_LIMIT > 15) ? 15 : STARVE_LIMIT);
  localparam bit         C_CAP_EN = (STARVE_LIMIT != 0);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_owner;
  logic [3:0]  r_streak;
  logic [31:0] r_rdata;

  logic        w_force_inst;
  logic        w_pick_data;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_grant;
  logic        w_capture;
  logic        w_sel_wr;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_strb;

  // Fetch is forced only once the data streak has reached the cap.
  assign w_force_inst = C_CAP_EN && inst_req && (r_streak == C_LIMIT);
  assign w_pick_data  = data_req && !w_force_inst;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (resetn) begin
          if (w_pick_data) begin
            w_grant_data = 1'b1;
            w_state_nxt  = ARB_ADDR;
          end else if (inst_req) begin
            w_grant_inst = 1'b1;
            w_state_nxt  = ARB_ADDR;
          end
        end
      end
      ARB_ADDR: begin
        if (mem_addr_ok) begin
          w_state_nxt = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (mem_data_ok) begin
          w_capture   = 1'b1;
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign w_grant      = w_grant_inst | w_grant_data;
  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  assign inst_data_ok = resetn && (r_state == ARB_RESP) && (r_owner == OWNER_INST);
  assign data_data_ok = resetn && (r_state == ARB_RESP) && (r_owner == OWNER_DATA);
  assign inst_rdata   = r_rdata;
  assign data_rdata   = r_rdata;

  assign w_sel_wr    = w_grant_data ? data_wr    : inst_wr;
  assign w_sel_size  = w_grant_data ? data_size  : inst_size;
  assign w_sel_addr  = w_grant_data ? data_addr  : inst_addr;
  assign w_sel_wdata = w_grant_data ? data_wdata : inst_wdata;

  mem_strb_gen u_strb_gen (
    .size    (w_sel_size),
    .addr_lo (w_sel_addr[1:0]),
    .wstrb   (w_sel_strb)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner   <= OWNER_INST;
      r_streak  <= 4'd0;
      r_rdata   <= 32'd0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_grant_data ? OWNER_DATA : OWNER_INST;
        mem_req   <= 1'b1;
        mem_wr    <= w_sel_wr;
        mem_wstrb <= w_sel_strb;
        mem_addr  <= w_sel_addr;
        mem_wdata <= w_sel_wdata;
      end else if ((r_state == ARB_ADDR) && mem_addr_ok) begin
        mem_req <= 1'b0;
      end

      // Read data is captured on writes too so rdata always reflects the last completion.
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end

      if (w_grant_data) begin
        if (inst_req) begin
          r_streak <= (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
        end else begin
          r_streak <= 4'd0;
        end
      end else if (w_grant_inst) begin
        r_streak <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a stallable memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE_LIMIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        z_inst_addr_ok, z_inst_data_ok, z_data_addr_ok, z_data_data_ok;
  logic [31:0] z_inst_rdata, z_data_rdata, z_mem_addr, z_mem_wdata;
  logic        z_mem_req, z_mem_wr;
  logic [3:0]  z_mem_wstrb;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // Pure data-priority instance with both requesters and the memory always ready.
  mem_port_arbiter #(.STARVE_LIMIT(0)) u_dut_nocap (
    .clk(clk), .resetn(resetn),
    .inst_req(1'b1), .inst_wr(1'b0), .inst_size(SZ_WORD),
    .inst_addr(32'hBFC0_0000), .inst_wdata(32'd0),
    .inst_addr_ok(z_inst_addr_ok), .inst_data_ok(z_inst_data_ok), .inst_rdata(z_inst_rdata),
    .data_req(1'b1), .data_wr(1'b0), .data_size(SZ_WORD),
    .data_addr(32'h8000_0000), .data_wdata(32'd0),
    .data_addr_ok(z_data_addr_ok), .data_data_ok(z_data_data_ok), .data_rdata(z_data_rdata),
    .mem_req(z_mem_req), .mem_wr(z_mem_wr), .mem_wstrb(z_mem_wstrb),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_addr_ok(1'b1), .mem_data_ok(1'b1), .mem_rdata(32'h0)
  );

  typedef struct {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    int          lat;
    int          gap;
  } txn_t;

  typedef struct {
    txn_t t;
    int   gcyc;
  } fl_t;

  txn_t        q_exp[$];
  txn_t        q_inst[$];
  txn_t        q_data[$];
  fl_t         q_flight[$];
  logic [31:0] q_mrd[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int last_grant = 0;
  int addr_wait  = 0;
  int data_wait  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing outstanding (cycle %0d)", name, cyc);
  endtask

  task automatic txn(input logic owner, input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] rdata, input int lat, input int gap);
    txn_t t;
    t.owner = owner; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    t.strb = strb; t.rdata = rdata; t.lat = lat; t.gap = gap;
    q_exp.push_back(t);
    q_mrd.push_back(rdata);
    if (owner == OWNER_DATA) q_data.push_back(t);
    else q_inst.push_back(t);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_exp.size() != 0 || q_flight.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(q_exp.size() + q_flight.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : drv_inst
    txn_t t;
    logic hs;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b00; inst_addr = '0; inst_wdata = '0;
    forever begin
      @(negedge clk);
      hs = inst_req && inst_addr_ok;
      @(posedge clk); #1;
      if (hs || !inst_req) begin
        if (q_inst.size() > 0) begin
          t = q_inst.pop_front();
          inst_req = 1'b1; inst_wr = t.wr; inst_size = t.size;
          inst_addr = t.addr; inst_wdata = t.wdata;
        end else begin
          inst_req = 1'b0;
        end
      end
    end
  end

  initial begin : drv_data
    txn_t t;
    logic hs;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = '0; data_wdata = '0;
    forever begin
      @(negedge clk);
      hs = data_req && data_addr_ok;
      @(posedge clk); #1;
      if (hs || !data_req) begin
        if (q_data.size() > 0) begin
          t = q_data.pop_front();
          data_req = 1'b1; data_wr = t.wr; data_size = t.size;
          data_addr = t.addr; data_wdata = t.wdata;
        end else begin
          data_req = 1'b0;
        end
      end
    end
  end

  initial begin : mem_model
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        repeat (addr_wait) @(negedge clk);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        repeat (data_wait) @(negedge clk);
        mem_data_ok = 1'b1;
        mem_rdata   = (q_mrd.size() > 0) ? q_mrd.pop_front() : 32'hDEAD_DEAD;
        @(negedge clk);
        mem_data_ok = 1'b0;
      end
    end
  end

  initial begin : monitor
    fl_t         f;
    txn_t        e;
    logic        prev_req;
    logic        s_wr;
    logic [3:0]  s_strb;
    logic [31:0] s_addr, s_wdata;
    prev_req = 1'b0; s_wr = 1'b0; s_strb = '0; s_addr = '0; s_wdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        q_flight.delete();
        prev_req = 1'b0;
      end else begin
        if (inst_addr_ok || data_addr_ok) begin
          chk("single_addr_ok", 32'(inst_addr_ok & data_addr_ok), 32'd0);
          if (q_exp.size() == 0) begin
            flag("unexpected_grant");
          end else begin
            e = q_exp.pop_front();
            chk("grant_owner", 32'(data_addr_ok), 32'(e.owner));
            if (e.gap != 0) chk("grant_spacing", 32'(cyc - last_grant), 32'(e.gap));
            last_grant = cyc;
            f.t = e; f.gcyc = cyc;
            q_flight.push_back(f);
          end
        end
        if (mem_req && !prev_req) begin
          if (q_flight.size() == 0) begin
            flag("mem_req_without_grant");
          end else begin
            f = q_flight[0];
            chk("mem_req_latency", 32'(cyc - f.gcyc), 32'd1);
            chk("mem_addr", mem_addr, f.t.addr);
            chk("mem_wr", 32'(mem_wr), 32'(f.t.wr));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(f.t.strb));
            chk("mem_wdata", mem_wdata, f.t.wdata);
            s_wr = mem_wr; s_strb = mem_wstrb; s_addr = mem_addr; s_wdata = mem_wdata;
          end
        end else if (mem_req) begin
          chk("stable_addr", mem_addr, s_addr);
          chk("stable_wstrb", 32'(mem_wstrb), 32'(s_strb));
          chk("stable_wdata", mem_wdata, s_wdata);
          chk("stable_wr", 32'(mem_wr), 32'(s_wr));
        end
        prev_req = mem_req;
        if (inst_data_ok || data_data_ok) begin
          chk("single_data_ok", 32'(inst_data_ok & data_data_ok), 32'd0);
          if (q_flight.size() == 0) begin
            flag("unexpected_data_ok");
          end else begin
            f = q_flight.pop_front();
            chk("resp_owner", 32'(data_data_ok), 32'(f.t.owner));
            chk("resp_rdata", f.t.owner ? data_rdata : inst_rdata, f.t.rdata);
            chk("resp_latency", 32'(cyc - f.gcyc), 32'(f.t.lat));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt_i, cnt_d, cnt_ri, cnt_rd, cnt_ok;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst_addr_ok", 32'(z_inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(z_data_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // STARVE_LIMIT=0 instance: data always wins, one grant every 4 cycles.
    cnt_i = 0; cnt_d = 0; cnt_ri = 0; cnt_rd = 0;
    repeat (40) begin
      @(negedge clk);
      cnt_i  += int'(z_inst_addr_ok);
      cnt_d  += int'(z_data_addr_ok);
      cnt_ri += int'(z_inst_data_ok);
      cnt_rd += int'(z_data_data_ok);
    end
    chk("nocap_inst_grants", 32'(cnt_i), 32'd0);
    chk("nocap_data_grants", 32'(cnt_d), 32'd10);
    chk("nocap_inst_data_ok", 32'(cnt_ri), 32'd0);
    chk("nocap_data_data_ok", 32'(cnt_rd), 32'd10);

    txn(OWNER_INST, 1'b0, SZ_WORD, 32'hBFC0_0000, 32'd0, 4'b1111, 32'h3C1D_0000, 3, 0);
    drain("drain_inst_read");

    txn(OWNER_DATA, 1'b1, SZ_BYTE, 32'h8000_1002, 32'h00AB_0000, 4'b0100, 32'h1111_1111, 3, 0);
    txn(OWNER_INST, 1'b0, SZ_WORD, 32'hBFC0_0004, 32'd0, 4'b1111, 32'h27BD_FFF8, 3, 4);
    drain("drain_simultaneous");

    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h1000_0000, 32'd0, 4'b1111, 32'hD000_0001, 3, 0);
    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h1000_0004, 32'd0, 4'b1111, 32'hD000_0002, 3, 4);
    txn(OWNER_INST, 1'b0, SZ_WORD, 32'hBFC0_0010, 32'd0, 4'b1111, 32'hA000_0001, 3, 4);
    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h1000_0008, 32'd0, 4'b1111, 32'hD000_0003, 3, 4);
    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h1000_000C, 32'd0, 4'b1111, 32'hD000_0004, 3, 4);
    txn(OWNER_INST, 1'b0, SZ_WORD, 32'hBFC0_0014, 32'd0, 4'b1111, 32'hA000_0002, 3, 4);
    drain("drain_starvation");

    addr_wait = 5; data_wait = 7;
    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h2000_0000, 32'd0, 4'b1111, 32'hCAFE_F00D, 15, 0);
    drain("drain_stall");
    addr_wait = 0; data_wait = 0;

    // Reset while the transaction sits in the data phase; its completion must vanish.
    data_wait = 6;
    txn(OWNER_DATA, 1'b0, SZ_WORD, 32'h3000_0000, 32'd0, 4'b1111, 32'hBAD0_0001, 0, 0);
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    cnt_ok = 0;
    repeat (12) begin
      @(negedge clk);
      cnt_ok += int'(inst_data_ok) + int'(data_data_ok);
    end
    chk("reset_drop_data_ok", 32'(cnt_ok), 32'd0);
    chk("reset_rdata", data_rdata, 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    data_wait = 0;

    txn(OWNER_DATA, 1'b1, SZ_HALF, 32'h4000_0002, 32'hBEEF_0000, 4'b1100, 32'h0000_0000, 3, 0);
    drain("drain_half_hi");
    txn(OWNER_DATA, 1'b1, 2'b11, 32'h4000_0001, 32'h1234_5678, 4'b1111, 32'h55AA_55AA, 3, 0);
    drain("drain_size11");
    txn(OWNER_INST, 1'b0, SZ_HALF, 32'h4000_0001, 32'd0, 4'b0011, 32'h0000_ABCD, 3, 0);
    drain("drain_half_lo");
    txn(OWNER_DATA, 1'b0, SZ_BYTE, 32'h4000_0003, 32'd0, 4'b1000, 32'h0000_00EF, 3, 0);
    drain("drain_byte3");
    chk("rdata_shared", inst_rdata, 32'h0000_00EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one variable-latency memory port between the instruction-fetch requester and the data-access requester of the 5-stage pipeline.
- Sits between the fetch/mem stages and the single memory (or bus bridge) port.
- Protocol on both sides is req/addr_ok/data_ok. One transaction is in flight at a time.
- Data side has priority. A starvation limiter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced; 0 = pure data priority (no override); max 15

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
inst_req / data_req  in  1  request valid, held until matching addr_ok
inst_wr / data_wr  in  1  1=write, 0=read
inst_size / data_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
inst_addr / data_addr  in  32  byte address
inst_wdata / data_wdata  in  32  write data, byte lanes already aligned by requester
inst_addr_ok / data_addr_ok  out  1  request accepted this cycle (combinational, IDLE only)
inst_data_ok / data_data_ok  out  1  one-cycle completion pulse (read data valid / write acked)
inst_rdata / data_rdata  out  32  both driven from the same registered rdata_q
mem_req  out  1  downstream request, registered
mem_wr  out  1  latched wr
mem_wstrb  out  4  byte enables (also driven for reads)
mem_addr  out  32  latched address, low 2 bits passed unchanged
mem_wdata  out  32  latched write data
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream completion
mem_rdata  in  32  downstream read data, valid with mem_data_ok

Behaviour:
- Reset: clk rising edge with resetn=0 forces state=IDLE, owner=0, streak=0, rdata_q=0, all mem_* regs 0.
- Addr_ok/data_ok outputs are 0 during and after reset. Reset mid-transaction drops it: no data_ok is ever issued for it.
- States: IDLE, ADDR, DATA, RESP (2-bit encoding).
- IDLE, selection:
  - If data_req and not (STARVE_LIMIT!=0 and inst_req and streak==STARVE_LIMIT), select data; else if inst_req, select inst.
  - The selected requester's addr_ok=1 this cycle.
  - Latch owner, wr, addr, wdata and wstrb into mem_* regs; mem_req<=1; next=ADDR.
- IDLE, streak counter: a data grant with inst_req=1 increments streak (saturating at 15). A data grant with inst_req=0, or any inst grant, clears it.
- ADDR: mem_req=1 with stable fields. On mem_addr_ok: mem_req<=0, next=DATA. Otherwise hold indefinitely.
- DATA: on mem_data_ok: rdata_q<=mem_rdata (captured on writes too), next=RESP. mem_data_ok outside DATA is ignored.
- RESP: owner's data_ok=1 for exactly one cycle; next=IDLE. No new grant in RESP; earliest next addr_ok is the cycle after RESP.
- Latency with zero-wait memory: addr_ok cycle N, mem_req high N+1, mem_data_ok N+2, data_ok N+3. Back-to-back grant spacing is 4 cycles.
- wstrb by size and addr[1:0]:
  - byte: 0001<<addr[1:0]
  - half: addr[1]?1100:0011 (addr[0] ignored)
  - word/11: 1111
- Simultaneous inst_req and data_req in IDLE: exactly one addr_ok is asserted, never both.
- The non-owner never sees data_ok. rdata holds its value until the next capture.

Decomposition:
- Shared package mem_arb_pkg: state encoding (ARB_IDLE..ARB_RESP), size codes (SZ_BYTE/SZ_HALF/SZ_WORD), OWNER_INST=0/OWNER_DATA=1.
- One combinational sub-module, mem_strb_gen (size, addr[1:0] -> wstrb), reusable by the mem stage.

Test Plan:
- Inst-only read of addr 0xBFC00000, zero-wait memory: inst_addr_ok at N, mem_req N+1 with wstrb=1111, inst_data_ok N+3 with inst_rdata=mem_rdata=0x3C1D0000.
- Simultaneous inst_req+data_req, data_wr=1, size=00, addr=0x...02: data_addr_ok only, mem_wstrb=0100. Inst is granted in the IDLE cycle after RESP.
- STARVE_LIMIT=2, data_req and inst_req held high: grant order data, data, inst, data, data, inst. Streak clears on every inst grant.
- Memory stalls mem_addr_ok 5 cycles and mem_data_ok 7 cycles: mem fields stay stable, no upstream pulses, then a single data_ok.
- resetn=0 while in DATA: next cycle state=IDLE, no data_ok even if mem_data_ok arrives; rdata=0.
- Half write at addr[1]=1 gives wstrb 1100; size=11 gives 1111; STARVE_LIMIT=0 never grants inst while data_req=1.
